// File: rtl/uart_pkg.sv
// Shared state encodings, parity constants and parity helper for the UART receiver.
package uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Unused upper bits of data must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_linefilt.sv
// RX line synchroniser followed by a 3-tap history and majority vote.
module uart_rx_linefilt #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_rx,
    output logic o_sync,
    output logic o_vote
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             hist_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sync_q <= '1;
            hist_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
            hist_q <= {hist_q[1:0], sync_q[SYNC_STAGES-1]};
        end
    end

    assign o_sync = hist_q[0];
    assign o_vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, data shifter and valid/ready output holding register.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   IDLE       | line high, waiting for a falling edge
//   START      | half-bit wait, confirm start bit at mid-bit
//   DATA       | sample DATA_BITS payload bits, LSB first
//   PARITY     | sample parity bit (only if parity enabled)
//   STOP       | sample stop bit(s), commit after the last one
//   WAIT_HIGH  | line still low after frame; wait for it to rise
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_uartrx,
    input  logic                 i_rxready,
    output logic                 o_rxdatval,
    output logic [DATA_BITS-1:0] o_rxdata,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_overrun
);

    import uart_pkg::*;

    localparam int              CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      IDX_LAST   = 4'(DATA_BITS - 1);
    localparam logic            STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic            HAS_PARITY = 1'(PARITY_MODE != PARITY_NONE);
    localparam logic            ODD_PARITY = 1'(PARITY_MODE == PARITY_ODD);

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q, frm_err_q, all_zero_q;
    logic                 line_sync, line_vote;

    logic bit_tick, start_ok, cnt_clr;
    logic data_smp, par_smp, stop_smp, commit;

    uart_rx_linefilt #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_linefilt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_rx   (i_uartrx),
        .o_sync (line_sync),
        .o_vote (line_vote)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (!line_sync) state_d = ST_START;
            ST_START:     if (cnt_q == CNT_HALF) state_d = line_vote ? ST_IDLE : ST_DATA;
            ST_DATA:      if (cnt_q == CNT_LAST && bit_idx_q == IDX_LAST)
                              state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (cnt_q == CNT_LAST) state_d = ST_STOP;
            ST_STOP:      if (cnt_q == CNT_LAST && stop_idx_q == STOP_LAST)
                              state_d = line_vote ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (line_vote) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_tick = (cnt_q == CNT_LAST);
        start_ok = (state_q == ST_START) && (cnt_q == CNT_HALF) && !line_vote;
        data_smp = (state_q == ST_DATA) && bit_tick;
        par_smp  = (state_q == ST_PARITY) && bit_tick;
        stop_smp = (state_q == ST_STOP) && bit_tick;
        commit   = stop_smp && (stop_idx_q == STOP_LAST);
        cnt_clr  = (state_q == ST_IDLE) || (state_q == ST_WAIT_HIGH) || bit_tick
                   || ((state_q == ST_START) && (cnt_q == CNT_HALF));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            all_zero_q   <= 1'b0;
            o_rxdatval   <= 1'b0;
            o_rxdata     <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            cnt_q <= cnt_clr ? '0 : cnt_q + 1'b1;

            if (start_ok) begin
                bit_idx_q  <= '0;
                stop_idx_q <= 1'b0;
                par_err_q  <= 1'b0;
                frm_err_q  <= 1'b0;
                all_zero_q <= 1'b1;
            end
            if (data_smp) begin
                shift_q    <= {line_vote, shift_q[DATA_BITS-1:1]};
                bit_idx_q  <= bit_idx_q + 1'b1;
                all_zero_q <= all_zero_q & ~line_vote;
            end
            if (par_smp) begin
                par_err_q  <= line_vote != parity_bit(9'(shift_q), ODD_PARITY);
                all_zero_q <= all_zero_q & ~line_vote;
            end
            if (stop_smp) begin
                stop_idx_q <= stop_idx_q + 1'b1;
                frm_err_q  <= frm_err_q | ~line_vote;
                all_zero_q <= all_zero_q & ~line_vote;
            end

            // A new frame never overwrites a word the consumer has not taken.
            o_overrun <= 1'b0;
            if (commit) begin
                if (o_rxdatval && !i_rxready) begin
                    o_overrun <= 1'b1;
                end else begin
                    o_rxdatval   <= 1'b1;
                    o_rxdata     <= shift_q;
                    o_parity_err <= par_err_q;
                    o_frame_err  <= frm_err_q | ~line_vote;
                    o_break      <= all_zero_q & ~line_vote;
                end
            end else if (o_rxdatval && i_rxready) begin
                o_rxdatval <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed and randomised frame tests for uart_rx_cfg across 8N1, 7E1, 7O1 and 8N2 builds.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
    } word_t;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic i_rstn, rx, rdy;

    logic       v_a, pe_a, fe_a, bk_a, ov_a;
    logic [7:0] d_a;
    logic       v_b, pe_b, fe_b, bk_b, ov_b;
    logic [6:0] d_b;
    logic       v_c, pe_c, fe_c, bk_c, ov_c;
    logic [6:0] d_c;
    logic       v_d, pe_d, fe_d, bk_d, ov_d;
    logic [7:0] d_d;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_8n1 (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_uartrx(rx), .i_rxready(rdy),
        .o_rxdatval(v_a), .o_rxdata(d_a), .o_parity_err(pe_a), .o_frame_err(fe_a),
        .o_break(bk_a), .o_overrun(ov_a));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1), .SYNC_STAGES(2)) dut_7e1 (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_uartrx(rx), .i_rxready(rdy),
        .o_rxdatval(v_b), .o_rxdata(d_b), .o_parity_err(pe_b), .o_frame_err(fe_b),
        .o_break(bk_b), .o_overrun(ov_b));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .SYNC_STAGES(2)) dut_7o1 (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_uartrx(rx), .i_rxready(rdy),
        .o_rxdatval(v_c), .o_rxdata(d_c), .o_parity_err(pe_c), .o_frame_err(fe_c),
        .o_break(bk_c), .o_overrun(ov_c));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .SYNC_STAGES(3)) dut_8n2 (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_uartrx(rx), .i_rxready(rdy),
        .o_rxdatval(v_d), .o_rxdata(d_d), .o_parity_err(pe_d), .o_frame_err(fe_d),
        .o_break(bk_d), .o_overrun(ov_d));

    // Words accepted by the consumer (valid & ready), plus valid/overrun cycle counts.
    word_t q[4][$];
    int    vcyc[4] = '{default: 0};
    int    ovr[4]  = '{default: 0};

    always @(negedge i_clk) begin
        if (v_a && rdy) q[0].push_back(word_t'({9'(d_a), pe_a, fe_a, bk_a}));
        if (v_b && rdy) q[1].push_back(word_t'({9'(d_b), pe_b, fe_b, bk_b}));
        if (v_c && rdy) q[2].push_back(word_t'({9'(d_c), pe_c, fe_c, bk_c}));
        if (v_d && rdy) q[3].push_back(word_t'({9'(d_d), pe_d, fe_d, bk_d}));
        vcyc[0] += int'(v_a);
        vcyc[1] += int'(v_b);
        vcyc[2] += int'(v_c);
        vcyc[3] += int'(v_d);
        ovr[0]  += int'(ov_a);
        ovr[1]  += int'(ov_b);
        ovr[2]  += int'(ov_c);
        ovr[3]  += int'(ov_d);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected word from the frame fields as they appear on the line.
    function automatic word_t model(input logic [8:0] data, input int nbits, input int pmode,
                                    input logic pbit, input int nstop, input logic [1:0] stops);
        word_t      w;
        logic [8:0] d;
        logic       exp_p, all_stop_low;
        d            = data & ((9'd1 << nbits) - 9'd1);
        exp_p        = (($countones(d) % 2) == 1) ^ (pmode == 2);
        all_stop_low = !stops[0] && (nstop == 1 || !stops[1]);
        w.data = d;
        w.pe   = (pmode != 0) && (pbit != exp_p);
        w.fe   = !stops[0] || (nstop == 2 && !stops[1]);
        w.brk  = (d == 9'd0) && (pmode == 0 || !pbit) && all_stop_low;
        return w;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b, input logic spike);
        for (int i = 0; i < CPB; i++) begin
            rx = (spike && i == CPB / 2) ? ~b : b;
            cyc(1);
        end
    endtask

    task automatic send_frame(input logic [8:0] data, input int nbits, input int has_par, input logic pbit,
                              input int nstop, input logic [1:0] stops, input logic [8:0] spikes);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i], spikes[i]);
        if (has_par != 0) send_bit(pbit, 1'b0);
        for (int i = 0; i < nstop; i++) send_bit(stops[i], 1'b0);
    endtask

    task automatic check_next(input int id, input word_t exp, input string tag);
        word_t got;
        chk({tag, " present"}, 64'(q[id].size() > 0), 64'd1);
        if (q[id].size() > 0) begin
            got = q[id].pop_front();
            chk(tag, 64'(got), 64'(exp));
        end
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, " valid"},   64'(v_a),  64'd0);
        chk({tag, " data"},    64'(d_a),  64'd0);
        chk({tag, " par_err"}, 64'(pe_a), 64'd0);
        chk({tag, " frm_err"}, 64'(fe_a), 64'd0);
        chk({tag, " break"},   64'(bk_a), 64'd0);
        chk({tag, " overrun"}, 64'(ov_a), 64'd0);
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        cyc(3);
        for (int i = 0; i < 4; i++) q[i].delete();
        i_rstn = 1'b1;
        cyc(2);
    endtask

    int         base_v, base_o;
    logic [8:0] rd;
    logic       rp;
    logic [1:0] rs;

    initial begin
        rx     = 1'b1;
        rdy    = 1'b1;
        i_rstn = 1'b0;
        cyc(4);
        chk_zero_a("reset");
        i_rstn = 1'b1;
        for (int i = 0; i < 4; i++) q[i].delete();
        cyc(2 * CPB);

        // 8N1 back-to-back frames
        base_v = vcyc[0];
        send_frame(9'hA5, 8, 0, 1'b0, 1, 2'b11, 9'h0);
        send_frame(9'h3C, 8, 0, 1'b0, 1, 2'b11, 9'h0);
        rx = 1'b1;
        cyc(2 * CPB);
        chk("8n1 word count", 64'(q[0].size()), 64'd2);
        chk("8n1 valid cycles", 64'(vcyc[0] - base_v), 64'd2);
        check_next(0, model(9'hA5, 8, 0, 1'b0, 1, 2'b11), "8n1 A5");
        check_next(0, model(9'h3C, 8, 0, 1'b0, 1, 2'b11), "8n1 3C");

        // 7-bit parity: same frame seen by even and odd receivers
        do_reset();
        send_frame(9'h55, 7, 1, 1'b1, 1, 2'b11, 9'h0);
        rx = 1'b1;
        cyc(2 * CPB);
        check_next(1, model(9'h55, 7, 1, 1'b1, 1, 2'b11), "7e1 55 p1");
        check_next(2, model(9'h55, 7, 2, 1'b1, 1, 2'b11), "7o1 55 p1");

        // Two stop bits, second low, line stays low afterwards
        do_reset();
        send_frame(9'h81, 8, 0, 1'b0, 2, 2'b01, 9'h0);
        rx = 1'b0;
        cyc(3 * CPB);
        chk("8n2 words while low", 64'(q[3].size()), 64'd1);
        check_next(3, model(9'h81, 8, 0, 1'b0, 2, 2'b01), "8n2 81 stop2 low");
        rx = 1'b1;
        cyc(2 * CPB);
        chk("8n2 no extra word", 64'(q[3].size()), 64'd0);
        send_frame(9'h5A, 8, 0, 1'b0, 2, 2'b11, 9'h0);
        rx = 1'b1;
        cyc(2 * CPB);
        check_next(3, model(9'h5A, 8, 0, 1'b0, 2, 2'b11), "8n2 5A after low");

        // Break: line low for 30 bit times
        do_reset();
        rx = 1'b0;
        cyc(30 * CPB);
        chk("break word count", 64'(q[0].size()), 64'd1);
        check_next(0, model(9'h00, 8, 0, 1'b0, 1, 2'b00), "break word");
        rx = 1'b1;
        cyc(3 * CPB);
        chk("break no retrigger", 64'(q[0].size()), 64'd0);
        send_frame(9'h96, 8, 0, 1'b0, 1, 2'b11, 9'h0);
        rx = 1'b1;
        cyc(2 * CPB);
        check_next(0, model(9'h96, 8, 0, 1'b0, 1, 2'b11), "after break 96");

        // Overrun with consumer stalled
        do_reset();
        rdy    = 1'b0;
        base_o = ovr[0];
        send_frame(9'h11, 8, 0, 1'b0, 1, 2'b11, 9'h0);
        rx = 1'b1;
        cyc(CPB);
        send_frame(9'h22, 8, 0, 1'b0, 1, 2'b11, 9'h0);
        rx = 1'b1;
        cyc(2 * CPB);
        chk("ovr valid held", 64'(v_a), 64'd1);
        chk("ovr held word", 64'({9'(d_a), pe_a, fe_a, bk_a}), 64'(model(9'h11, 8, 0, 1'b0, 1, 2'b11)));
        chk("ovr pulse cycles", 64'(ovr[0] - base_o), 64'd1);
        rdy = 1'b1;
        cyc(1);
        chk("ovr valid dropped", 64'(v_a), 64'd0);
        check_next(0, model(9'h11, 8, 0, 1'b0, 1, 2'b11), "ovr accepted 11");

        // Short low pulse on an idle line
        do_reset();
        rx = 1'b0;
        cyc(3);
        rx = 1'b1;
        cyc(3 * CPB);
        chk("glitch no word", 64'(q[0].size()), 64'd0);
        chk("glitch valid", 64'(v_a), 64'd0);

        // Single-cycle spikes at data-bit midpoints
        send_frame(9'hF0, 8, 0, 1'b0, 1, 2'b11, 9'h011);
        rx = 1'b1;
        cyc(2 * CPB);
        check_next(0, model(9'hF0, 8, 0, 1'b0, 1, 2'b11), "spike F0");

        // Reset in the middle of a data bit, with a word held
        rdy = 1'b0;
        send_frame(9'h77, 8, 0, 1'b0, 1, 2'b11, 9'h0);
        rx = 1'b1;
        cyc(CPB);
        chk("pre-reset valid held", 64'(v_a), 64'd1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        rx = 1'b0;
        cyc(CPB / 2);
        i_rstn = 1'b0;
        cyc(2);
        chk_zero_a("mid reset");
        i_rstn = 1'b1;
        rx     = 1'b1;
        rdy    = 1'b1;
        for (int i = 0; i < 4; i++) q[i].delete();
        cyc(2 * CPB);
        chk("mid reset no partial", 64'(q[0].size()), 64'd0);
        send_frame(9'h42, 8, 0, 1'b0, 1, 2'b11, 9'h0);
        rx = 1'b1;
        cyc(2 * CPB);
        check_next(0, model(9'h42, 8, 0, 1'b0, 1, 2'b11), "after reset 42");

        // Random 8N1 frames, occasional bad stop / zero payload
        do_reset();
        for (int n = 0; n < 8; n++) begin
            rd = 9'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) rd = 9'h0;
            rs = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
            send_frame(rd, 8, 0, 1'b0, 1, rs, 9'h0);
            rx = 1'b1;
            cyc(2 * CPB);
            check_next(0, model(rd, 8, 0, 1'b0, 1, rs), "rand 8n1");
        end

        // Random 7-bit parity frames, random parity bit
        do_reset();
        for (int n = 0; n < 8; n++) begin
            rd = 9'($urandom_range(0, 127));
            if ($urandom_range(0, 5) == 0) rd = 9'h0;
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
            send_frame(rd, 7, 1, rp, 1, rs, 9'h0);
            rx = 1'b1;
            cyc(2 * CPB);
            check_next(1, model(rd, 7, 1, rp, 1, rs), "rand 7e1");
            check_next(2, model(rd, 7, 2, rp, 1, rs), "rand 7o1");
        end

        // Random 8N2 frames, random stop bits
        do_reset();
        for (int n = 0; n < 6; n++) begin
            rd = 9'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) rd = 9'h0;
            rs = 2'($urandom_range(0, 3));
            send_frame(rd, 8, 0, 1'b0, 2, rs, 9'h0);
            rx = 1'b1;
            cyc(2 * CPB);
            check_next(3, model(rd, 8, 0, 1'b0, 2, rs), "rand 8n2");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised UART receiver; next generation of the sample-stream serial receiver feeding BRAM/FIR sample loading.
- Adds configurable data width, parity, 1/2 stop bits, 3-tap majority sampling, and valid/ready output holding.
- Adds parity, framing, break and overrun reporting.
- Sits between the board RX pin and the byte/sample assembler.

Parameters:
- CLKS_PER_BIT, 1250, i_clk cycles per bit; must be >= 8.
- DATA_BITS, 8, payload bits per frame; legal values 5..9.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- SYNC_STAGES, 2, synchroniser flops on i_uartrx; must be >= 2.

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  reset, synchronous, active-low
- i_uartrx  in  1  asynchronous serial line, idle high
- i_rxready  in  1  consumer accepts the current word
- o_rxdatval  out  1  word valid; held until accepted
- o_rxdata  out  DATA_BITS  received payload, LSB first on the line
- o_parity_err  out  1  parity mismatch for the current word
- o_frame_err  out  1  a stop bit was sampled low for the current word
- o_break  out  1  break: all data bits, parity and stop bits were 0
- o_overrun  out  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset (i_rstn=0 at posedge): state IDLE, counters 0; o_rxdatval, o_rxdata, all error flags, and o_overrun = 0. Synchroniser and vote flops are preset to 1.
- Reset mid-frame aborts the frame; no partial word is ever presented.
- Line path: SYNC_STAGES flops, then a 3-deep history shift register. vote = majority of the 3 history bits.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: newest synced bit = 0 -> START, cnt = 0.
- START: cnt increments. At cnt = CLKS_PER_BIT/2 - 1:
  - vote = 0 -> DATA, cnt = 0, bit index = 0.
  - vote = 1 -> IDLE (glitch rejected).
- DATA: at cnt = CLKS_PER_BIT - 1, shift vote into the data register at the current bit index and set cnt = 0.
  - After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY: same timing as a data bit.
  - Expected bit = XOR of the data bits, inverted when PARITY_MODE = 2.
  - Mismatch sets the pending parity error.
- STOP: sample each stop bit at cnt = CLKS_PER_BIT - 1; any low sample sets the pending frame error.
  - After the last stop sample (mid-bit), commit the frame.
  - Then go to IDLE if vote = 1, else WAIT_HIGH. No trailing half-bit wait.
- Break: all data bits, the parity bit (if present) and all stop bits sampled 0 -> o_break = 1 and o_frame_err = 1; the word is delivered with data = 0.
- WAIT_HIGH: stay until vote = 1, then IDLE. This prevents a retrigger during a break or line fault.
- Commit, latency: o_rxdatval rises 1 cycle after the final stop sample. Data and flags are loaded in the same cycle.
- Handshake: a transfer occurs on a cycle with o_rxdatval & i_rxready. o_rxdatval drops on the next cycle unless a commit occurs in that same cycle.
  - Commit together with a transfer: the new word is loaded and valid stays 1.
- Overrun: commit while o_rxdatval=1 and i_rxready=0 -> the new frame is discarded and the held word and flags are unchanged. o_overrun = 1 for exactly 1 cycle.
- Output register contents are stable while o_rxdatval = 1 and not accepted.
- Counter width is $clog2(CLKS_PER_BIT). No arithmetic wraps within a frame.

Decomposition:
- Package uart_pkg:
  - state encoding localparams (3-bit);
  - PARITY_NONE / EVEN / ODD constants;
  - function for the expected parity bit.
- Sub-module uart_rx_linefilt: SYNC_STAGES synchroniser, 3-tap history, outputs o_sync (newest bit) and o_vote. Reset preset to 1.
- Top module holds the FSM, data shift register, and output holding register.

Test Plan (CLKS_PER_BIT=16):
- 8N1, frame 0xA5, i_rxready=1 -> o_rxdatval pulses 1 cycle with o_rxdata=0xA5, all flags 0. Then back-to-back frame 0x3C -> o_rxdata=0x3C, no gap errors.
- DATA_BITS=7, PARITY_MODE=1, frame 0x55 with parity bit forced to 1 -> o_rxdata=0x55, o_parity_err=1. Repeat with PARITY_MODE=2 and the same frame -> o_parity_err=0.
- STOP_BITS=2, second stop bit driven low for 0x81 -> o_frame_err=1, o_rxdata=0x81. FSM waits in WAIT_HIGH until the line goes high.
- Line held low for 30 bit times -> exactly one word, with o_rxdata=0, o_break=1, o_frame_err=1. No further words until the line returns high and a new start bit arrives.
- i_rxready=0, send 0x11 then 0x22 -> o_rxdata stays 0x11, o_overrun pulses 1 cycle at the second commit. Raising i_rxready then drops o_rxdatval next cycle.
- Glitch tests:
  - a 3-cycle low pulse on an idle line -> no word;
  - a 1-cycle inverted spike at a data-bit midpoint of 0xF0 -> still 0xF0 (majority vote);
  - i_rstn low mid-DATA -> all outputs 0, next clean frame 0x42 received correctly.
